// File: rtl/seq_det_pkg.sv
// Shared constants for the parameterised serial pattern detector.
package seq_det_pkg;

  // Legal ranges for the pattern length and the number of pattern slots.
  localparam int unsigned NMin      = 2;
  localparam int unsigned NMax      = 8;
  localparam int unsigned NumPatMin = 1;
  localparam int unsigned NumPatMax = 4;

  // Default geometry and reset pattern set: slot 0 = 101, slot 1 = 110.
  localparam int unsigned DefaultN      = 3;
  localparam int unsigned DefaultNumPat = 2;
  localparam logic [DefaultNumPat*DefaultN-1:0] DefaultPat = {3'b110, 3'b101};
  localparam bit DefaultOvl = 1'b0;

endpackage

// File: rtl/seq_det_slot.sv
// One pattern slot: N-bit compare of the current window against its pattern.
module seq_det_slot #(
  parameter int unsigned N = 3
) (
  input  logic [N-1:0] window_i,
  input  logic [N-1:0] pattern_i,
  output logic         eq_o
);

  // Pure equality; qualification by fill level and cfg_load happens in the top.
  always_comb begin
    eq_o = (window_i == pattern_i);
  end

endmodule

// File: rtl/seq_det_param.sv
// Parameterised multi-pattern serial sequence detector with optional
// registered (Moore-style) outputs and a saturating match counter.
module seq_det_param
  import seq_det_pkg::*;
#(
  parameter int unsigned          N           = DefaultN,
  parameter int unsigned          NUM_PAT     = DefaultNumPat,
  parameter bit                   MOORE       = 1'b0,
  parameter int unsigned          CNT_W       = 8,
  parameter logic [NUM_PAT*N-1:0] DEFAULT_PAT = DefaultPat,
  parameter bit                   DEFAULT_OVL = DefaultOvl
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   in,
  input  logic                   cfg_load,
  input  logic [NUM_PAT*N-1:0]   cfg_pattern,
  input  logic                   cfg_overlap,
  output logic [NUM_PAT-1:0]     hit,
  output logic                   out,
  output logic [CNT_W-1:0]       match_cnt
);

  if (N < NMin || N > NMax || NUM_PAT < NumPatMin || NUM_PAT > NumPatMax) begin : g_bad_param
    $error("seq_det_param: N or NUM_PAT outside the legal range");
  end

  localparam int unsigned      CntBits  = $clog2(N);
  localparam logic [CntBits-1:0] CntFull = CntBits'(N - 1);
  localparam logic [CNT_W-1:0] MatchMax = {CNT_W{1'b1}};

  logic [N-2:0]           hist_q, hist_d;
  logic [CntBits-1:0]     cnt_q, cnt_d;
  logic [NUM_PAT*N-1:0]   pat_q, pat_d;
  logic                   ovl_q, ovl_d;
  logic [CNT_W-1:0]       mcnt_q, mcnt_d;

  logic [N-1:0]           window;
  logic [NUM_PAT-1:0]     slot_eq;
  logic [NUM_PAT-1:0]     match_vec;
  logic                   any_match;

  // Oldest bit in the MSB, current input bit in the LSB.
  assign window = {hist_q, in};

  for (genvar k = 0; k < NUM_PAT; k++) begin : g_slot
    seq_det_slot #(
      .N(N)
    ) u_slot (
      .window_i  (window),
      .pattern_i (pat_q[k*N +: N]),
      .eq_o      (slot_eq[k])
    );
  end

  // A slot only matches once N fresh bits are present and no reload is pending.
  always_comb begin
    match_vec = '0;
    if (cnt_q == CntFull && !cfg_load) begin
      match_vec = slot_eq;
    end
    any_match = |match_vec;
  end

  // Next-state: reload has priority; a non-overlapping match restarts every slot.
  always_comb begin
    hist_d = hist_q;
    cnt_d  = cnt_q;
    pat_d  = pat_q;
    ovl_d  = ovl_q;
    mcnt_d = mcnt_q;
    if (cfg_load) begin
      pat_d  = cfg_pattern;
      ovl_d  = cfg_overlap;
      hist_d = '0;
      cnt_d  = '0;
    end else begin
      hist_d = window[N-2:0];
      if (any_match && !ovl_q) begin
        cnt_d = '0;
      end else if (cnt_q != CntFull) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    // Simultaneous slot matches count as a single event.
    if (any_match && mcnt_q != MatchMax) begin
      mcnt_d = mcnt_q + 1'b1;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hist_q <= '0;
      cnt_q  <= '0;
      pat_q  <= DEFAULT_PAT;
      ovl_q  <= DEFAULT_OVL;
      mcnt_q <= '0;
    end else begin
      hist_q <= hist_d;
      cnt_q  <= cnt_d;
      pat_q  <= pat_d;
      ovl_q  <= ovl_d;
      mcnt_q <= mcnt_d;
    end
  end

  if (MOORE) begin : g_moore
    logic [NUM_PAT-1:0] hit_q;

    // Registered hit vector: flags appear one cycle after the completing edge.
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        hit_q <= '0;
      end else begin
        hit_q <= match_vec;
      end
    end

    assign hit = hit_q;
  end else begin : g_mealy
    assign hit = match_vec;
  end

  assign out       = |hit;
  assign match_cnt = mcnt_q;

endmodule

// File: tb/tb_seq_det_param.sv
// Self-checking bench for seq_det_param: directed vector table, saturation and
// Moore-delay sequences, then randomized traffic against a queue-based model.
module tb_seq_det_param;
  import seq_det_pkg::*;

  localparam int NB = 3;
  localparam logic [5:0] DP = DefaultPat;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default-parameter DUT.
  logic       a_rstn, a_in, a_load, a_ovl, a_out;
  logic [5:0] a_pat;
  logic [1:0] a_hit;
  logic [7:0] a_cnt;

  // CNT_W=4 DUTs, Mealy and Moore, sharing stimulus.
  logic       b_rstn, b_in, b_load, b_ovl, o1, o2;
  logic [5:0] b_pat;
  logic [1:0] h1, h2;
  logic [3:0] c1, c2;

  seq_det_param u_dut0 (
    .clk(clk), .rstn(a_rstn), .in(a_in), .cfg_load(a_load), .cfg_pattern(a_pat),
    .cfg_overlap(a_ovl), .hit(a_hit), .out(a_out), .match_cnt(a_cnt)
  );

  seq_det_param #(.CNT_W(4), .MOORE(1'b0)) u_dut1 (
    .clk(clk), .rstn(b_rstn), .in(b_in), .cfg_load(b_load), .cfg_pattern(b_pat),
    .cfg_overlap(b_ovl), .hit(h1), .out(o1), .match_cnt(c1)
  );

  seq_det_param #(.CNT_W(4), .MOORE(1'b1)) u_dut2 (
    .clk(clk), .rstn(b_rstn), .in(b_in), .cfg_load(b_load), .cfg_pattern(b_pat),
    .cfg_overlap(b_ovl), .hit(h2), .out(o2), .match_cnt(c2)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  typedef struct {
    bit         rstn_v;
    bit         in_v;
    bit         load_v;
    logic [5:0] pat_v;
    bit         ovl_v;
    logic [1:0] exp_hit;
    logic [7:0] exp_cnt;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input bit r, input bit i, input bit l, input logic [5:0] p, input bit o,
                     input logic [1:0] eh, input int ec);
    vec_t v;
    v.rstn_v = r; v.in_v = i; v.load_v = l; v.pat_v = p; v.ovl_v = o;
    v.exp_hit = eh; v.exp_cnt = 8'(ec);
    tbl.push_back(v);
  endtask

  // Behavioural model: keep only the bits usable since the last restart.
  int         m_bits[$];
  logic [5:0] m_pat;
  bit         m_ovl;
  int         m_cnt;

  function automatic logic [1:0] m_expect(input bit inb, input bit load, input bit rst);
    logic [1:0] h;
    int v;
    h = 2'b00;
    if (rst || load || m_bits.size() < NB - 1) return h;
    v = 0;
    for (int j = 0; j < NB - 1; j++) v = v * 2 + m_bits[m_bits.size() - (NB - 1) + j];
    v = v * 2 + int'(inb);
    for (int k = 0; k < 2; k++) begin
      if (v == int'((m_pat >> (k * NB)) & 6'd7)) h[k] = 1'b1;
    end
    return h;
  endfunction

  task automatic m_update(input bit rst, input bit inb, input bit load, input logic [5:0] pat,
                          input bit ovl, input logic [1:0] h);
    if (rst) begin
      m_bits.delete();
      m_pat = DP; m_ovl = 1'b0; m_cnt = 0;
    end else if (load) begin
      m_bits.delete();
      m_pat = pat; m_ovl = ovl;
    end else begin
      m_bits.push_back(int'(inb));
      if (h != 2'b00) begin
        if (m_cnt < 255) m_cnt++;
        if (!m_ovl) m_bits.delete();
      end
      while (m_bits.size() > NB - 1) void'(m_bits.pop_front());
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int nhit1;
    a_rstn = 1'b0; a_in = 1'b0; a_load = 1'b0; a_pat = DP; a_ovl = 1'b0;
    b_rstn = 1'b0; b_in = 1'b0; b_load = 1'b0; b_pat = DP; b_ovl = 1'b0;
    #1;
    check("reset_hit0", 32'(a_hit), 32'h0);
    check("reset_out0", 32'(a_out), 32'h0);
    check("reset_cnt0", 32'(a_cnt), 32'h0);
    check("reset_hit2", 32'(h2), 32'h0);
    @(negedge clk);
    @(negedge clk);
    a_rstn = 1'b1; b_rstn = 1'b1;

    // Directed vectors; expected match_cnt is the value after the edge.
    add(1,1,0,DP,0,2'b00,0); add(1,0,0,DP,0,2'b00,0); add(1,1,0,DP,0,2'b01,1);
    add(1,0,0,DP,0,2'b00,1); add(1,1,0,DP,0,2'b00,1);
    add(1,0,1,DP,1,2'b00,1);
    add(1,1,0,DP,1,2'b00,1); add(1,0,0,DP,1,2'b00,1); add(1,1,0,DP,1,2'b01,2);
    add(1,0,0,DP,1,2'b00,2); add(1,1,0,DP,1,2'b01,3);
    add(1,0,1,DP,0,2'b00,3);
    add(1,1,0,DP,0,2'b00,3); add(1,1,0,DP,0,2'b00,3); add(1,0,0,DP,0,2'b10,4);
    add(1,1,0,DP,0,2'b00,4);
    add(1,0,1,DP,1,2'b00,4);
    add(1,1,0,DP,1,2'b00,4); add(1,1,0,DP,1,2'b00,4); add(1,0,0,DP,1,2'b10,5);
    add(1,1,0,DP,1,2'b01,6);
    add(1,0,1,6'b101101,0,2'b00,6);
    add(1,1,0,DP,0,2'b00,6); add(1,0,0,DP,0,2'b00,6); add(1,1,0,DP,0,2'b11,7);
    add(1,0,1,DP,0,2'b00,7);
    add(1,1,0,DP,0,2'b00,7); add(1,0,0,DP,0,2'b00,7);
    add(0,0,0,DP,0,2'b00,0); add(0,0,0,DP,0,2'b00,0);
    add(1,1,0,DP,0,2'b00,0); add(1,0,0,DP,0,2'b00,0); add(1,1,0,DP,0,2'b01,1);
    add(1,1,0,DP,0,2'b00,1); add(1,0,0,DP,0,2'b00,1);
    add(1,1,1,DP,0,2'b00,1);
    add(1,1,0,DP,0,2'b00,1); add(1,0,0,DP,0,2'b00,1); add(1,1,0,DP,0,2'b01,2);

    for (int i = 0; i < tbl.size(); i++) begin
      a_rstn = tbl[i].rstn_v; a_in = tbl[i].in_v; a_load = tbl[i].load_v;
      a_pat = tbl[i].pat_v; a_ovl = tbl[i].ovl_v;
      #1;
      check($sformatf("vec%0d_hit", i), 32'(a_hit), 32'(tbl[i].exp_hit));
      check($sformatf("vec%0d_out", i), 32'(a_out), 32'(|tbl[i].exp_hit));
      @(posedge clk); #1;
      check($sformatf("vec%0d_cnt", i), 32'(a_cnt), 32'(tbl[i].exp_cnt));
      @(negedge clk);
    end
    a_rstn = 1'b1; a_load = 1'b0;

    // Saturation and Moore delay: both slots 111, overlapping, 22 ones.
    b_load = 1'b1; b_pat = 6'b111111; b_ovl = 1'b1;
    @(negedge clk);
    b_load = 1'b0;
    nhit1 = 0;
    for (int i = 1; i <= 22; i++) begin
      b_in = 1'b1;
      #1;
      if (h1 != 2'b00) nhit1++;
      check($sformatf("sat%0d_hit1", i), 32'(h1), (i >= 3) ? 32'h3 : 32'h0);
      check($sformatf("sat%0d_hit2", i), 32'(h2), (i >= 4) ? 32'h3 : 32'h0);
      check($sformatf("sat%0d_out2", i), 32'(o2), (i >= 4) ? 32'h1 : 32'h0);
      @(posedge clk); #1;
      check($sformatf("sat%0d_cnt1", i), 32'(c1),
            32'((i - 2 < 0) ? 0 : ((i - 2 > 15) ? 15 : i - 2)));
      check($sformatf("sat%0d_cnt2", i), 32'(c2),
            32'((i - 2 < 0) ? 0 : ((i - 2 > 15) ? 15 : i - 2)));
      @(negedge clk);
    end
    check("sat_match_cycles", 32'(nhit1), 32'd20);
    b_in = 1'b0;
    #1;
    check("tail_hit1", 32'(h1), 32'h0);
    check("tail_hit2", 32'(h2), 32'h3);
    @(negedge clk);
    #1;
    check("tail2_hit2", 32'(h2), 32'h0);
    check("tail2_cnt2", 32'(c2), 32'd15);

    // Randomized traffic on the default DUT against the model.
    @(negedge clk);
    a_rstn = 1'b0;
    m_update(1'b1, 1'b0, 1'b0, DP, 1'b0, 2'b00);
    @(negedge clk);
    for (int i = 0; i < 600; i++) begin
      logic [1:0] eh;
      bit r;
      r = ($urandom_range(0, 63) != 0);
      a_rstn = r;
      a_in = 1'($urandom_range(0, 1));
      a_load = ($urandom_range(0, 15) == 0);
      a_pat = 6'($urandom_range(0, 63));
      a_ovl = 1'($urandom_range(0, 1));
      eh = m_expect(a_in, a_load, !r);
      #1;
      check($sformatf("rnd%0d_hit", i), 32'(a_hit), 32'(eh));
      check($sformatf("rnd%0d_out", i), 32'(a_out), 32'(|eh));
      m_update(!r, a_in, a_load, a_pat, a_ovl, eh);
      @(posedge clk); #1;
      check($sformatf("rnd%0d_cnt", i), 32'(a_cnt), 32'(m_cnt));
      @(negedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/seq_det_param.md
SEQ_DET_PARAM -- requirements
Module: seq_det_param

Interface
REQ-001 SHALL take parameter N, default 3: pattern length in bits, legal 2..8.
REQ-002 SHALL take parameter NUM_PAT, default 2: number of pattern slots, legal 1..4.
REQ-003 SHALL take parameter MOORE, default 0: 0 = Mealy outputs, 1 = outputs registered one cycle later.
REQ-004 SHALL take parameter CNT_W, default 8: match counter width.
REQ-005 SHALL take parameter DEFAULT_PAT, default {3'b110,3'b101}: reset pattern set; slot k occupies bits [k*N +: N], MSB is the oldest bit.
REQ-006 SHALL take parameter DEFAULT_OVL, default 0: reset overlap mode.
REQ-007 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-008 SHALL have port rstn, input, 1 bit: asynchronous, active-low reset.
REQ-009 SHALL have port in, input, 1 bit: serial data bit, sampled on each rising clk edge.
REQ-010 SHALL have port cfg_load, input, 1 bit: strobe that loads cfg_pattern and cfg_overlap.
REQ-011 SHALL have port cfg_pattern, input, NUM_PAT*N bits: new pattern set, same packing as DEFAULT_PAT.
REQ-012 SHALL have port cfg_overlap, input, 1 bit: 1 = overlapping detection, 0 = non-overlapping.
REQ-013 SHALL have port hit, output, NUM_PAT bits: per-slot match flag.
REQ-014 SHALL have port out, output, 1 bit: OR of hit.
REQ-015 SHALL have port match_cnt, output, CNT_W bits: count of match events, saturating.

Function
REQ-016 SHALL keep state: hist (N-1 most recent bits), fill count cnt (0..N-1, saturating), pattern registers, overlap register.
REQ-017 SHALL, when MOORE=0, assert hit[k] combinationally when cnt==N-1, cfg_load==0 and {hist,in}==pattern[k]; the flag marks the cycle that presents the final bit.
REQ-018 SHALL, when MOORE=1, register the REQ-017 hit vector, so hit/out are high for exactly one cycle after the completing edge.
REQ-019 SHALL, on each rising edge with cfg_load==0, shift in into hist.
REQ-020 SHALL, on the same edge, set cnt to 0 if a match occurs and overlap==0, otherwise to min(cnt+1, N-1).
REQ-021 SHALL, in non-overlapping mode, let a match on any slot restart detection for all slots, so no slot can use a bit already consumed by a match.
REQ-022 SHALL count multiple slots matching in the same cycle as one event: match_cnt increments by 1 and hit shows every matching slot.
REQ-023 SHALL increment match_cnt on each edge where a REQ-017 match exists, saturating at 2^CNT_W-1; it does not wrap.
REQ-024 SHALL, on an edge with cfg_load==1, load pattern and overlap, clear hist and cnt, and discard that cycle's in bit; cfg_load takes priority over detection.
REQ-025 SHALL keep the REQ-017 match at 0 during a cfg_load cycle; match_cnt is not cleared by cfg_load.

Reset
REQ-026 SHALL, while rstn==0, asynchronously clear hist, cnt, match_cnt and any MOORE output registers to 0.
REQ-027 SHALL, while rstn==0, set the pattern registers to DEFAULT_PAT and overlap to DEFAULT_OVL; hit and out read 0.
REQ-028 SHALL discard any partial sequence on reset asserted mid-stream; detection after release needs N fresh bits.

Structure
REQ-029 SHALL place the legal-range constants for N and NUM_PAT, and the default pattern constants, in package seq_det_pkg.
REQ-030 SHALL instantiate sub-module seq_det_slot (N-bit compare of {hist,in} against one pattern) once per slot via generate.

Verification
Default parameters apply unless stated; bit streams are listed in time order.
REQ-031 SHALL cover: overlap=0, stream 1,0,1,0,1 -> out high only on bit 3, hit=2'b01, match_cnt=1.
REQ-032 SHALL cover: cfg_load with overlap=1, same stream -> out high on bits 3 and 5, match_cnt=2.
REQ-033 SHALL cover: stream 1,1,0,1 -> overlap=0 gives hit=2'b10 on bit 3 only; overlap=1 also gives hit=2'b01 on bit 4.
REQ-034 SHALL cover: cfg_load both slots=101, stream 1,0,1 -> hit=2'b11 on bit 3, match_cnt increments by exactly 1.
REQ-035 SHALL cover: stream 1,0, then rstn low for 2 cycles, release, then 1 -> no hit; also cfg_load between bits 2 and 3 -> no hit.
REQ-036 SHALL cover: CNT_W=4, pattern 111, overlap=1, 22 ones -> 20 match cycles, match_cnt holds at 15; MOORE=1 variant -> every hit delayed exactly one cycle.
